// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing signals from the timing generator to the renderer
interface vga_timing_gen_if;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic hSync;
  logic vSync;
  logic bright;
  logic pix_tick;
  logic frame_tick;
  logic game_tick;
  modport master(output hCount, vCount, hSync, vSync, bright, pix_tick, frame_tick, game_tick);
  modport slave(input hCount, vCount, hSync, vSync, bright, pix_tick, frame_tick, game_tick);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel divider, 800x525 raster counters, registered sync/bright and frame/game pulses
module vga_timing_gen #(
  parameter int CLK_DIV     = 4,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_START = 144,
  parameter int H_ACT_END   = 783,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_ACT_START = 35,
  parameter int V_ACT_END   = 514,
  parameter int FRAME_DIV   = 1
) (
  input  logic clk,
  input  logic rst_n,
  vga_timing_gen_if.master vga
);
  logic [3:0] div_cnt;
  logic [7:0] fcnt;
  logic pix, h_end, v_end, frame;
  logic [9:0] h_nxt, v_nxt;
  always_comb begin
    pix   = div_cnt == 4'(CLK_DIV - 1);
    h_end = vga.hCount == 10'(H_TOTAL - 1);
    v_end = vga.vCount == 10'(V_TOTAL - 1);
    frame = pix && h_end && v_end;
    h_nxt = pix ? (h_end ? 10'd0 : vga.hCount + 10'd1) : vga.hCount;
    v_nxt = (pix && h_end) ? (v_end ? 10'd0 : vga.vCount + 10'd1) : vga.vCount;
  end
  assign vga.pix_tick   = pix;
  assign vga.frame_tick = frame;
  assign vga.game_tick  = frame && fcnt == 8'(FRAME_DIV - 1);
  // sync/bright are derived from next-state counters so they line up with the counters they describe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      fcnt       <= '0;
      vga.hCount <= '0;
      vga.vCount <= '0;
      vga.hSync  <= 1'b0;
      vga.vSync  <= 1'b0;
      vga.bright <= 1'b0;
    end else begin
      div_cnt    <= pix ? 4'd0 : div_cnt + 4'd1;
      vga.hCount <= h_nxt;
      vga.vCount <= v_nxt;
      vga.hSync  <= h_nxt >= 10'(H_SYNC);
      vga.vSync  <= v_nxt >= 10'(V_SYNC);
      vga.bright <= h_nxt >= 10'(H_ACT_START) && h_nxt <= 10'(H_ACT_END) &&
                    v_nxt >= 10'(V_ACT_START) && v_nxt <= 10'(V_ACT_END);
      if (frame) fcnt <= (fcnt == 8'(FRAME_DIV - 1)) ? 8'd0 : fcnt + 8'd1;
    end
  end
endmodule
